// File: rtl/csr_trap_ctrl.sv
// SYSTEM-instruction sequencer between the IDU and the CSR unit.
// Optional trap counter port perf_traps enabled by CSR_TRAP_PERF_EN.
module csr_trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0] in_pc,
    output logic [2:0]      csr_ctl,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_pc,
    output logic            csr_wen,
    output logic            csr_commit,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic [XLEN-1:0] csr_upc,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    output logic            illegal,
    output logic            halt
`ifdef CSR_TRAP_PERF_EN
    ,
    output logic [XLEN-1:0] perf_traps
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_REDIR,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_MRET   = 3'b001;
    localparam logic [2:0] OP_ECALL  = 3'b010;
    localparam logic [2:0] OP_EBREAK = 3'b011;
    localparam logic [2:0] OP_CSRW   = 3'b100;

    state_t r_state;
    state_t w_next;

    logic [2:0]      r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rd_data;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_rd_valid;
    logic            r_illegal;
    logic            r_halt;

    logic w_accept;
    logic w_legal;
    logic w_issue;
    logic w_in_halt;

    assign w_legal   = (in_op == OP_MRET) || (in_op == OP_ECALL) ||
                       (in_op == OP_EBREAK) || (in_op == OP_CSRW);
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_issue   = (r_state == S_ISSUE);
    assign w_in_halt = (r_state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_legal) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unique case (r_op)
                    OP_ECALL, OP_MRET: w_next = S_REDIR;
                    OP_EBREAK:         w_next = S_HALT;
                    default:           w_next = S_IDLE;
                endcase
            end
            S_REDIR: begin
                if (redir_ready) begin
                    w_next = S_IDLE;
                end
            end
            S_HALT: w_next = S_HALT;
        endcase
    end

    // Only legal ops are latched, so csr_* never show an unissued command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            r_rd_data  <= '0;
            r_redir_pc <= '0;
            r_rd_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_rd_valid <= w_issue && (r_op == OP_CSRW);
            r_illegal  <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_op    <= in_op;
                r_addr  <= in_csr_addr;
                r_wdata <= in_wdata;
                r_pc    <= in_pc;
            end
            if (w_issue && (r_op == OP_CSRW)) begin
                r_rd_data <= csr_rdata;
            end
            if (w_issue && ((r_op == OP_ECALL) || (r_op == OP_MRET))) begin
                r_redir_pc <= csr_upc;
            end
            if (w_issue && (r_op == OP_EBREAK)) begin
                r_halt <= 1'b1;
            end
        end
    end

`ifdef CSR_TRAP_PERF_EN
    logic [XLEN-1:0] r_perf_traps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_traps <= '0;
        end else if (w_issue && (r_op == OP_ECALL)) begin
            r_perf_traps <= r_perf_traps + XLEN'(1);
        end
    end

    assign perf_traps = r_perf_traps;
`endif

    assign csr_ctl    = w_issue ? r_op : 3'b000;
    assign csr_wen    = w_issue && ((r_op == OP_CSRW) || (r_op == OP_ECALL));
    assign csr_commit = w_issue && (r_op != OP_EBREAK);
    assign csr_addr   = w_in_halt ? '0 : r_addr;
    assign csr_wdata  = w_in_halt ? '0 : r_wdata;
    assign csr_pc     = w_in_halt ? '0 : r_pc;

    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign redir_valid = (r_state == S_REDIR);
    assign redir_pc    = r_redir_pc;
    assign illegal     = r_illegal;
    assign halt        = r_halt;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a tiny mtvec/mepc CSR model.
module tb_csr_trap_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = 3'b000;
    logic [11:0]     in_csr_addr = '0;
    logic [XLEN-1:0] in_wdata = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic [2:0]      csr_ctl;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_pc;
    logic            csr_wen;
    logic            csr_commit;
    logic [XLEN-1:0] csr_rdata;
    logic [XLEN-1:0] csr_upc;
    logic            rd_valid;
    logic [XLEN-1:0] rd_data;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            redir_ready = 1'b0;
    logic            illegal;
    logic            halt;
`ifdef CSR_TRAP_PERF_EN
    logic [XLEN-1:0] perf_traps;
`endif

    int checks = 0;
    int errors = 0;
    int n_commit = 0;

    logic [XLEN-1:0] mtvec = 32'h0000_1000;
    logic [XLEN-1:0] mepc  = 32'h0000_0000;

    csr_trap_ctrl #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_csr_addr (in_csr_addr),
        .in_wdata    (in_wdata),
        .in_pc       (in_pc),
        .csr_ctl     (csr_ctl),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_pc      (csr_pc),
        .csr_wen     (csr_wen),
        .csr_commit  (csr_commit),
        .csr_rdata   (csr_rdata),
        .csr_upc     (csr_upc),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready),
        .illegal     (illegal),
        .halt        (halt)
`ifdef CSR_TRAP_PERF_EN
        ,
        .perf_traps  (perf_traps)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural CSR unit: mtvec at 0x305, mepc at 0x341.
    always_comb begin
        csr_rdata = '0;
        if (csr_addr == 12'h305) csr_rdata = mtvec;
        else if (csr_addr == 12'h341) csr_rdata = mepc;
        csr_upc = '0;
        if (csr_ctl == 3'b010) csr_upc = mtvec;
        else if (csr_ctl == 3'b001) csr_upc = mepc;
    end

    always @(posedge clk) begin
        if (csr_commit) n_commit <= n_commit + 1;
        if (csr_commit && csr_wen) begin
            if (csr_ctl == 3'b100 && csr_addr == 12'h305) mtvec <= csr_wdata;
            if (csr_ctl == 3'b100 && csr_addr == 12'h341) mepc <= csr_wdata;
            if (csr_ctl == 3'b010) mepc <= csr_pc;
        end
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] a,
                         input logic [XLEN-1:0] d, input logic [XLEN-1:0] p);
        in_valid    = 1'b1;
        in_op       = op;
        in_csr_addr = a;
        in_wdata    = d;
        in_pc       = p;
    endtask

    initial begin
        int c0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_commit", 32'(csr_commit), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_redir_pc", redir_pc, 0);
        chk("rst_halt", 32'(halt), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        // CSRW mtvec
        drive(3'b100, 12'h305, 32'h8000_0100, 32'h0000_0040);
        tick();
        in_valid = 1'b0;
        chk("csrw_ctl", 32'(csr_ctl), 4);
        chk("csrw_wen", 32'(csr_wen), 1);
        chk("csrw_commit", 32'(csr_commit), 1);
        chk("csrw_addr", 32'(csr_addr), 32'h305);
        chk("csrw_wdata", csr_wdata, 32'h8000_0100);
        chk("csrw_busy", 32'(in_ready), 0);
        tick();
        chk("csrw_rd_valid", 32'(rd_valid), 1);
        chk("csrw_rd_data", rd_data, 32'h0000_1000);
        chk("csrw_ready2", 32'(in_ready), 1);
        chk("csrw_commit2", 32'(csr_commit), 0);
        tick();
        chk("csrw_rd_pulse", 32'(rd_valid), 0);

        // ECALL with redirect stall
        drive(3'b010, 12'h000, 32'h0, 32'h8000_0020);
        tick();
        in_valid = 1'b0;
        chk("ecall_ctl", 32'(csr_ctl), 2);
        chk("ecall_commit", 32'(csr_commit), 1);
        chk("ecall_wen", 32'(csr_wen), 1);
        chk("ecall_pc", csr_pc, 32'h8000_0020);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ecall_redir_v", 32'(redir_valid), 1);
            chk("ecall_redir_pc", redir_pc, 32'h8000_0100);
            chk("ecall_no_commit", 32'(csr_commit), 0);
            chk("ecall_no_ready", 32'(in_ready), 0);
        end
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("ecall_redir_done", 32'(redir_valid), 0);
        chk("ecall_ready", 32'(in_ready), 1);
        chk("ecall_commits", 32'(n_commit), 2);
        chk("ecall_mepc", mepc, 32'h8000_0020);

        // MRET with redir_ready already high
        redir_ready = 1'b1;
        drive(3'b001, 12'h000, 32'h0, 32'h0000_0000);
        tick();
        in_valid = 1'b0;
        chk("mret_ctl", 32'(csr_ctl), 1);
        chk("mret_wen", 32'(csr_wen), 0);
        chk("mret_commit", 32'(csr_commit), 1);
        tick();
        chk("mret_redir_v", 32'(redir_valid), 1);
        chk("mret_redir_pc", redir_pc, 32'h8000_0020);
        tick();
        redir_ready = 1'b0;
        chk("mret_redir_1cyc", 32'(redir_valid), 0);
        chk("mret_ready", 32'(in_ready), 1);

        // Illegal opcode
        drive(3'b111, 12'h305, 32'hDEAD_BEEF, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_no_issue", 32'(csr_ctl), 0);
        chk("ill_ready", 32'(in_ready), 1);
        tick();
        chk("ill_pulse_end", 32'(illegal), 0);
        chk("ill_commits", 32'(n_commit), 3);

        // Back-to-back CSRW with in_valid held high
        c0 = n_commit;
        drive(3'b100, 12'h305, 32'hA5A5_0000, 32'h0);
        tick();
        chk("b2b_issue1", 32'(csr_commit), 1);
        tick();
        chk("b2b_rd1", rd_data, 32'h8000_0100);
        chk("b2b_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_issue2", 32'(csr_commit), 1);
        tick();
        chk("b2b_rd2", rd_data, 32'hA5A5_0000);
        tick();
        chk("b2b_count", 32'(n_commit - c0), 2);

        // Reset while an ECALL redirect is pending
        drive(3'b010, 12'h000, 32'h0, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        tick();
        chk("rr_redir_v", 32'(redir_valid), 1);
        chk("rr_redir_pc", redir_pc, 32'hA5A5_0000);
`ifdef CSR_TRAP_PERF_EN
        chk("perf_count", perf_traps, 2);
`endif
        c0 = n_commit;
        rst = 1'b1;
        #1;
        chk("rr_async_drop", 32'(redir_valid), 0);
        chk("rr_in_ready", 32'(in_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rr_ready", 32'(in_ready), 1);
        chk("rr_redir_pc0", redir_pc, 0);
        chk("rr_rd_data0", rd_data, 0);
        chk("rr_addr0", 32'(csr_addr), 0);
`ifdef CSR_TRAP_PERF_EN
        chk("perf_reset", perf_traps, 0);
`endif
        tick();
        chk("rr_no_commit", 32'(n_commit - c0), 0);
        chk("rr_idle", 32'(redir_valid), 0);

        // EBREAK halts until reset
        c0 = n_commit;
        drive(3'b011, 12'h341, 32'h0, 32'h0000_0200);
        tick();
        in_valid = 1'b0;
        chk("ebrk_ctl", 32'(csr_ctl), 3);
        chk("ebrk_commit", 32'(csr_commit), 0);
        chk("ebrk_wen", 32'(csr_wen), 0);
        tick();
        chk("ebrk_halt", 32'(halt), 1);
        chk("ebrk_ready", 32'(in_ready), 0);
        drive(3'b100, 12'h305, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_sticky", 32'(halt), 1);
            chk("halt_ready", 32'(in_ready), 0);
            chk("halt_ctl", 32'(csr_ctl), 0);
            chk("halt_addr", 32'(csr_addr), 0);
        end
        in_valid = 1'b0;
        chk("halt_commits", 32'(n_commit - c0), 0);
        chk("halt_mtvec", mtvec, 32'hA5A5_0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("halt_cleared", 32'(halt), 0);
        chk("halt_ready_back", 32'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Sequencing initiator for the CSR unit: accepts decoded SYSTEM-class instructions (CSRW, ECALL, MRET, EBREAK) from the IDU over a valid/ready handshake. For each one it issues a single qualified command to the CSR unit, then captures the read data or the trap/return target. It delivers a PC redirect to the IFU, or raises halt. It sits between the IDU and the CSR unit and owns the commit strobe that gates every CSR update.

## Interface
Parameters:
- XLEN, 32, data/PC width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  IDU presents a SYSTEM instruction.
- in_ready  out  1  controller can accept.
- in_op  in  3  001 MRET, 010 ECALL, 011 EBREAK, 100 CSRW; other codes are illegal.
- in_csr_addr  in  12  CSR address.
- in_wdata  in  XLEN  CSRW write data.
- in_pc  in  XLEN  PC of the instruction.
- csr_ctl  out  3  command to the CSR unit.
- csr_addr  out  12  address to the CSR unit.
- csr_wdata  out  XLEN  write data to the CSR unit.
- csr_pc  out  XLEN  PC to the CSR unit (captured as mepc on ECALL).
- csr_wen  out  1  write enable to the CSR unit.
- csr_commit  out  1  one-cycle commit strobe; the CSR unit writes only when csr_commit && csr_wen.
- csr_rdata  in  XLEN  combinational CSR read data.
- csr_upc  in  XLEN  combinational trap/return target (mtvec for ECALL, mepc for MRET).
- rd_valid  out  1  one-cycle pulse: rd_data holds the old CSR value.
- rd_data  out  XLEN  captured CSR read value.
- redir_valid  out  1  redirect request to the IFU.
- redir_pc  out  XLEN  redirect target.
- redir_ready  in  1  IFU accepts the redirect.
- illegal  out  1  one-cycle pulse on an illegal in_op.
- halt  out  1  sticky; set by EBREAK.

## Operation
- States: IDLE, ISSUE, REDIR, HALT. Reset state is IDLE.
- in_ready is 1 only in IDLE with rst low.
- IDLE:
  - On in_valid && in_ready, latch op, addr, wdata and pc into command registers, then go to ISSUE.
  - Legal ops go to ISSUE. Illegal ops pulse illegal for one cycle and stay in IDLE.
- ISSUE lasts exactly one cycle:
  - csr_ctl = latched op.
  - csr_addr, csr_wdata and csr_pc are driven from the command registers.
  - csr_wen = 1 for CSRW and ECALL, 0 otherwise.
  - csr_commit = 1 for CSRW, ECALL and MRET. For EBREAK it stays 0.
- ISSUE exit, by op:
  - CSRW: capture csr_rdata (the pre-write value) into rd_data, pulse rd_valid next cycle, return to IDLE.
  - ECALL/MRET: capture csr_upc into redir_pc, go to REDIR.
  - EBREAK: set halt, go to HALT.
- REDIR: redir_valid = 1 and redir_pc stays stable until redir_ready is seen high on a clock edge, then return to IDLE. No new instruction is accepted meanwhile.
- HALT: terminal. in_ready = 0 and all command outputs are 0 until rst.
- Outside ISSUE, csr_ctl, csr_wen and csr_commit are 0. csr_addr, csr_wdata and csr_pc hold their last values.
- MRET target is the raw mepc; no +4 is applied (software adjusts mepc).

## Timing
- Reset values: state IDLE; command registers, rd_data, redir_pc = 0; all valid/pulse outputs, halt, csr_wen, csr_commit, csr_ctl = 0; in_ready = 0 while rst is high.
- Latencies from the accept edge:
  - ISSUE in cycle +1.
  - CSRW: rd_valid in cycle +2; next accept at the earliest in cycle +2.
  - ECALL/MRET: redir_valid from cycle +2.
  - EBREAK: halt from cycle +2.
- csr_commit is exactly one cycle per legal non-EBREAK instruction. It never repeats while REDIR stalls.
- csr_rdata and csr_upc are sampled at the end of the ISSUE cycle. ECALL's mtvec target is unaffected by its own mepc/mcause write.
- redir_ready already high when REDIR is entered: REDIR lasts one cycle.
- Reset mid-operation: FSM aborts immediately. No commit is issued after rst rises. Pending redirect and halt are dropped. CSR contents are not touched by this block.
- in_valid held high across back-to-back instructions: each instruction is accepted once, and only in IDLE.

## Configuration
- CSR_TRAP_PERF_EN defined:
  - Adds output perf_traps (XLEN), reset to 0.
  - Increments by 1 on each ECALL ISSUE cycle and wraps at 2^XLEN.
- CSR_TRAP_PERF_EN undefined: no port and no counter logic.

## Test plan
- CSRW addr 0x305 data 0x80000100 -> one ISSUE cycle with csr_ctl=100, csr_wen=1, csr_commit=1; rd_valid in cycle +2 with the old mtvec value.
- mtvec=0x80000100, ECALL at pc 0x80000020 -> commit with csr_pc=0x80000020; redir_pc=0x80000100; redir_valid held 3 cycles while redir_ready=0, then clears.
- mepc=0x80000020, MRET -> csr_wen=0, csr_commit=1; redir_pc=0x80000020; redir_ready high on entry gives a 1-cycle redir_valid.
- EBREAK -> csr_commit never asserts; halt=1 from cycle +2; in_ready stays 0; in_valid then ignored until rst.
- in_op=111 -> illegal pulses 1 cycle, no ISSUE, in_ready stays 1.
- rst asserted during REDIR of an ECALL -> redir_valid drops asynchronously; after release state is IDLE, outputs at reset values, no further commit. With CSR_TRAP_PERF_EN, perf_traps=0.
